flag_register_bank: RTL and testbench
=====================================

// Module: flag_register_bank
// PURPOSE
//  Parametrised condition-flag register: WIDTH flags (default NZCV), per-flag write
//  enables, a same-cycle bypass output and a DEPTH-entry save/restore LIFO for
//  nested exception/call flag preservation.
//  Sits between the ALU flag outputs and the branch/condition logic of the ARM core.
// PARAMETERS
//  WIDTH      4        number of flags (bit3=N, bit2=Z, bit1=C, bit0=V at default)
//  DEPTH      4        save-stack entries (>=1)
//  RESET_VAL  '0       flag value loaded on reset (WIDTH bits)
// PORTS
//  clk    in   1                  clock; all state updates on posedge
//  reset  in   1                  synchronous, active-high
//  d      in   WIDTH              new flag values from ALU
//  en     in   WIDTH              per-flag write enable
//  push   in   1                  save committed flags q onto stack
//  pop    in   1                  restore top-of-stack into flags
//  q      out  WIDTH              registered (committed) flags
//  out    out  WIDTH              next-state flags (combinational bypass = q after edge)
//  count  out  $clog2(DEPTH+1)    stack occupancy
//  empty  out  1                  count==0
//  full   out  1                  count==DEPTH
//  err    out  1                  sticky stack-misuse flag
// BEHAVIOUR
//  - Reset (sync, high): q=RESET_VAL, count=0, empty=1, full=0, err=0; stack RAM not
//    cleared. reset dominates every other input in that cycle.
//  - Legal ops: push_ok = push & ~pop & ~full; pop_ok = pop & ~push & ~empty.
//  - Per bit i: next[i] = en[i] ? d[i] : (pop_ok ? top[i] : q[i]); en wins over restore.
//  - out = next (combinational, zero latency); q <= next each posedge (1-cycle latency).
//  - push_ok: stack[count] <= q (pre-update value, not d); count+1. Same-cycle en
//    still updates q.
//  - pop_ok: count-1; top = stack[count-1] sampled combinationally this cycle.
//  - push & pop together: both ignored, count unchanged, err unchanged; flags follow en/d.
//  - push while full (no pop): ignored, err<=1. pop while empty (no push): ignored,
//    flags keep q unless en, err<=1.
//  - err clears only on reset. full/empty/count are registered-state decodes, no bypass.
//  - No wrap-around: stack never overwrites or underflows; count saturates at 0..DEPTH.
//  - en='0, push=pop=0: hold state indefinitely.
// STRUCTURE
//  - Package flag_pkg: FLAG_W=4, index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1,
//    FLAG_V=0, typedef logic [FLAG_W-1:0] flags_t.
//  - Sub-module flag_stack #(WIDTH,DEPTH): LIFO storage, count, full/empty,
//    push_ok/pop_ok, top. Top level holds q, per-bit next-state mux, err.
// TESTING
//  1. reset=1 one edge, RESET_VAL=4'b0000 -> q=0000, count=0, empty=1, full=0, err=0.
//  2. q=0000, d=1111, en=0101 -> out=0101 same cycle; q=0101 after edge; en=0 holds 0101.
//  3. q=1010: push; next cycle d=0001 en=1111 -> q=0001; then pop -> q=1010, count=0,
//     empty=1.
//  4. Fill: 4 pushes of q=0001,0010,0100,1000 -> full=1; 5th push -> count stays 4,
//     err=1; 4 pops restore 1000,0100,0010,0001 in order.
//  5. pop on empty with en=0 -> q unchanged, err=1; push&pop together at count=2
//     -> count=2, err unchanged.
//  6. Stack top=1100, pop with d=0011 en=0001 -> q=1101; reset asserted mid-sequence
//     with push=1 -> count=0, q=RESET_VAL, err=0.

Source files
------------

// File: rtl/flag_pkg.sv
// Shared flag-register definitions: NZCV bit positions and the default flag vector type.
package flag_pkg;

  localparam int unsigned FLAG_W = 4;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  typedef logic [FLAG_W-1:0] flags_t;

endpackage : flag_pkg

// File: rtl/flag_stack.sv
// Save/restore LIFO for the flag register: storage, occupancy, legal-op decode and
// a combinational top-of-stack read.
module flag_stack #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CntW  = $clog2(DEPTH + 1),
  localparam int unsigned AddrW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [CntW-1:0]  count_o,
  output logic             empty_o,
  output logic             full_o,
  output logic             push_ok_o,
  output logic             pop_ok_o,
  output logic [WIDTH-1:0] top_o
);

  logic [WIDTH-1:0] mem_q [2**AddrW];
  logic [CntW-1:0]  count_q, count_d;
  logic [CntW-1:0]  count_m1;
  logic [AddrW-1:0] wr_idx, rd_idx;

  assign empty_o   = (count_q == '0);
  assign full_o    = (count_q == CntW'(DEPTH));
  assign push_ok_o = push_i & ~pop_i & ~full_o;
  assign pop_ok_o  = pop_i & ~push_i & ~empty_o;

  assign count_m1 = count_q - CntW'(1);
  assign wr_idx   = count_q[AddrW-1:0];
  assign rd_idx   = count_m1[AddrW-1:0];
  assign top_o    = mem_q[rd_idx];
  assign count_o  = count_q;

  always_comb begin
    count_d = count_q;
    if (push_ok_o) begin
      count_d = count_q + CntW'(1);
    end else if (pop_ok_o) begin
      count_d = count_m1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Storage is deliberately not cleared on reset; only occupancy is.
  always_ff @(posedge clk_i) begin
    if (!reset_i && push_ok_o) begin
      mem_q[wr_idx] <= wdata_i;
    end
  end

endmodule : flag_stack

// File: rtl/flag_register_bank.sv
// Condition-flag register with per-bit write enables, zero-latency next-state bypass
// and a nested save/restore stack.
module flag_register_bank
  import flag_pkg::*;
#(
  parameter int unsigned      WIDTH     = FLAG_W,
  parameter int unsigned      DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int unsigned     CntW      = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] en,
  input  logic             push,
  input  logic             pop,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] out,
  output logic [CntW-1:0]  count,
  output logic             empty,
  output logic             full,
  output logic             err
);

  logic [WIDTH-1:0] flags_q, flags_d;
  logic [WIDTH-1:0] top;
  logic             push_ok, pop_ok;
  logic             err_q, err_d;

  flag_stack #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_stack (
    .clk_i     (clk),
    .reset_i   (reset),
    .push_i    (push),
    .pop_i     (pop),
    .wdata_i   (flags_q),
    .count_o   (count),
    .empty_o   (empty),
    .full_o    (full),
    .push_ok_o (push_ok),
    .pop_ok_o  (pop_ok),
    .top_o     (top)
  );

  // ALU write enables take priority over a restore on a per-bit basis.
  always_comb begin
    flags_d = (en & d) | (~en & (pop_ok ? top : flags_q));
    err_d   = err_q | (push & ~pop & full) | (pop & ~push & empty);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q <= RESET_VAL;
      err_q   <= 1'b0;
    end else begin
      flags_q <= flags_d;
      err_q   <= err_d;
    end
  end

  assign q   = flags_q;
  assign out = flags_d;
  assign err = err_q;

endmodule : flag_register_bank

// File: tb/tb_flag_register_bank.sv
// Directed-vector bench for flag_register_bank with hand-computed expectations.
module tb_flag_register_bank;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] d, en;
  logic       push, pop;
  logic [3:0] q, out;
  logic [2:0] count;
  logic       empty, full, err;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  flag_register_bank #(
    .WIDTH     (4),
    .DEPTH     (4),
    .RESET_VAL (4'b0000)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .d     (d),
    .en    (en),
    .push  (push),
    .pop   (pop),
    .q     (q),
    .out   (out),
    .count (count),
    .empty (empty),
    .full  (full),
    .err   (err)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [3:0] dd, input logic [3:0] ee,
                       input logic pu, input logic po);
    reset = r;
    d     = dd;
    en    = ee;
    push  = pu;
    pop   = po;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [3:0] v);
    drive(1'b0, v, 4'b1111, 1'b0, 1'b0);
    tick();
  endtask

  logic [3:0] fill_vals [4];

  initial begin
    fill_vals[0] = 4'b0001;
    fill_vals[1] = 4'b0010;
    fill_vals[2] = 4'b0100;
    fill_vals[3] = 4'b1000;

    // Reset state
    drive(1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0);
    tick();
    check_eq("rst_q", q, 4'b0000);
    check_eq("rst_count", count, 0);
    check_eq("rst_empty", empty, 1);
    check_eq("rst_full", full, 0);
    check_eq("rst_err", err, 0);

    // Per-bit enables and bypass
    drive(1'b0, 4'b1111, 4'b0101, 1'b0, 1'b0);
    check_eq("en_bypass_out", out, 4'b0101);
    tick();
    check_eq("en_q", q, 4'b0101);
    drive(1'b0, 4'b1010, 4'b0000, 1'b0, 1'b0);
    tick();
    check_eq("hold_q", q, 4'b0101);

    // Save, overwrite, restore
    load(4'b1010);
    drive(1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0);
    tick();
    check_eq("push_count", count, 1);
    load(4'b0001);
    check_eq("overwrite_q", q, 4'b0001);
    drive(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1);
    check_eq("pop_bypass_out", out, 4'b1010);
    tick();
    check_eq("pop_q", q, 4'b1010);
    check_eq("pop_count", count, 0);
    check_eq("pop_empty", empty, 1);

    // Fill to full, overflow, drain in LIFO order
    for (int i = 0; i < 4; i++) begin
      load(fill_vals[i]);
      drive(1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0);
      tick();
    end
    check_eq("fill_count", count, 4);
    check_eq("fill_full", full, 1);
    check_eq("fill_err", err, 0);
    drive(1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0);
    tick();
    check_eq("ovf_count", count, 4);
    check_eq("ovf_err", err, 1);
    for (int i = 3; i >= 0; i--) begin
      drive(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1);
      tick();
      check_eq($sformatf("drain_q%0d", i), q, fill_vals[i]);
    end
    check_eq("drain_empty", empty, 1);

    // push&pop together, then underflow
    drive(1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0);
    tick();
    drive(1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0);
    tick();
    tick();
    check_eq("pp_pre_count", count, 2);
    drive(1'b0, 4'b0001, 4'b0011, 1'b1, 1'b1);
    tick();
    check_eq("pp_count", count, 2);
    check_eq("pp_err", err, 0);
    check_eq("pp_q", q, 4'b0001);
    drive(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1);
    tick();
    tick();
    load(4'b0110);
    drive(1'b0, 4'b1111, 4'b0000, 1'b0, 1'b1);
    tick();
    check_eq("unf_q", q, 4'b0110);
    check_eq("unf_count", count, 0);
    check_eq("unf_err", err, 1);

    // Enable beats restore per bit; reset dominates push
    drive(1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0);
    tick();
    load(4'b1100);
    drive(1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0);
    tick();
    load(4'b0010);
    drive(1'b0, 4'b0011, 4'b0001, 1'b0, 1'b1);
    check_eq("mix_out", out, 4'b1101);
    tick();
    check_eq("mix_q", q, 4'b1101);
    drive(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1);
    tick();
    drive(1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0);
    tick();
    check_eq("pre_rst_err", err, 1);
    check_eq("pre_rst_count", count, 1);
    drive(1'b1, 4'b1111, 4'b1111, 1'b1, 1'b0);
    tick();
    check_eq("rst2_count", count, 0);
    check_eq("rst2_q", q, 4'b0000);
    check_eq("rst2_err", err, 0);
    check_eq("rst2_empty", empty, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_flag_register_bank
